wd_supervisor: RTL

Multi-channel watchdog supervisor and shutdown sequencer. It monitors up to N_CH motor heartbeat inputs, each with its own inactivity timer. When any enabled channel goes silent, it runs a staged shutdown: brake first, then power-off after a fixed hold. It sits between the motor heartbeat lines and the power stage, and replaces per-line shutdown triggering with one coordinated, latched, software-clearable sequence.

---
 rtl/wd_pkg.sv | 19 +
 rtl/wd_channel.sv | 45 ++++
 rtl/wd_supervisor.sv | 107 ++++++++++
 3 files changed

// File: rtl/wd_pkg.sv
// Shared definitions for the watchdog supervisor: FSM encodings and default timing.
package wd_pkg;

  typedef enum logic [1:0] {
    WD_ARM   = 2'd0,
    WD_RUN   = 2'd1,
    WD_BRAKE = 2'd2,
    WD_OFF   = 2'd3
  } wd_state_e;

  localparam logic [1:0] ST_ARM   = WD_ARM;
  localparam logic [1:0] ST_RUN   = WD_RUN;
  localparam logic [1:0] ST_BRAKE = WD_BRAKE;
  localparam logic [1:0] ST_OFF   = WD_OFF;

  localparam int ARM_CYC_DEF    = 250;
  localparam int BRAKE_HOLD_DEF = 50;

endpackage

// File: rtl/wd_channel.sv
// One heartbeat monitor: synchronizer, any-edge kick detect, saturating inactivity counter.
// Latency: hb_in edge clears the counter on the 3rd clock edge; expired is combinational from flops.
// No backpressure: heartbeats are sampled every cycle.
module wd_channel #(
  parameter int CNT_W = 8
) (
  input  logic             clk_1khz,
  input  logic             rst_n,
  input  logic             hb_in,
  input  logic             ch_en,
  input  logic             hold,
  input  logic [CNT_W-1:0] timeout_reg,
  output logic             expired
);
  import wd_pkg::*;

  logic [2:0]       sync_q;
  logic [CNT_W-1:0] cnt;
  logic             kick;

  always_ff @(posedge clk_1khz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], hb_in};
    end
  end

  // Either polarity of heartbeat transition counts as a kick.
  assign kick = sync_q[1] ^ sync_q[2];

  always_ff @(posedge clk_1khz or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (hold || !ch_en || kick) begin
      cnt <= '0;
    end else if (cnt < timeout_reg) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A kick in the same cycle always beats expiry.
  assign expired = (cnt == timeout_reg) && !kick;

endmodule

// File: rtl/wd_supervisor.sv
// Multi-channel watchdog: arms, monitors heartbeats, then runs a latched brake -> power-off sequence.
// Latency: trip to brake_out 1 cycle, brake_out to pwr_off BRAKE_HOLD cycles, clr_req to outputs low 1 cycle.
// No backpressure: clr_req is a single-cycle request, honoured only in OFF with no enabled channel expired.
module wd_supervisor
  import wd_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 8,
  parameter int ARM_CYC    = ARM_CYC_DEF,
  parameter int BRAKE_HOLD = BRAKE_HOLD_DEF
) (
  input  logic             clk_1khz,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  hb_in,
  input  logic [N_CH-1:0]  ch_en,
  input  logic [CNT_W-1:0] timeout,
  input  logic             clr_req,
  output logic             brake_out,
  output logic             pwr_off,
  output logic [N_CH-1:0]  fault_ch,
  output logic [1:0]       state
);

  localparam int AW = $clog2(ARM_CYC + 1);
  localparam int HW = $clog2(BRAKE_HOLD + 1);
  localparam logic [AW-1:0] ARM_LAST  = AW'(ARM_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(BRAKE_HOLD - 1);

  logic [N_CH-1:0]  expired;
  logic [N_CH-1:0]  exp_mask;
  logic             trip;
  logic             arming;
  logic [AW-1:0]    arm_cnt;
  logic [HW-1:0]    hold_cnt;
  logic [CNT_W-1:0] timeout_reg;

  assign arming   = (state == ST_ARM);
  assign exp_mask = expired & ch_en;
  assign trip     = |exp_mask;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    wd_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk_1khz    (clk_1khz),
      .rst_n       (rst_n),
      .hb_in       (hb_in[i]),
      .ch_en       (ch_en[i]),
      .hold        (arming),
      .timeout_reg (timeout_reg),
      .expired     (expired[i])
    );
  end

  always_ff @(posedge clk_1khz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_ARM;
      arm_cnt     <= '0;
      hold_cnt    <= '0;
      timeout_reg <= CNT_W'(1);
      brake_out   <= 1'b0;
      pwr_off     <= 1'b0;
      fault_ch    <= '0;
    end else begin
      case (state)
        ST_ARM: begin
          if (arm_cnt == ARM_LAST) begin
            state   <= ST_RUN;
            arm_cnt <= '0;
            // A zero limit would expire every idle cycle; treat it as one.
            timeout_reg <= (timeout == '0) ? CNT_W'(1) : timeout;
          end else begin
            arm_cnt <= arm_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (trip) begin
            state     <= ST_BRAKE;
            brake_out <= 1'b1;
            fault_ch  <= fault_ch | exp_mask;
            hold_cnt  <= '0;
          end
        end
        ST_BRAKE: begin
          if (hold_cnt == HOLD_LAST) begin
            state   <= ST_OFF;
            pwr_off <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_OFF: begin
          // Recovery needs every enabled channel alive again.
          if (clr_req && !trip) begin
            state     <= ST_ARM;
            arm_cnt   <= '0;
            brake_out <= 1'b0;
            pwr_off   <= 1'b0;
            fault_ch  <= '0;
          end
        end
        default: state <= ST_ARM;
      endcase
    end
  end

endmodule
